// File: rtl/mem_req_router_pkg.sv
// Shared SMAC memory-port constants and elaboration helpers for the load router.
package mem_req_router_pkg;

  localparam int unsigned MEM_ADDR_W = 48;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned SMAC_TAG_W = 2;
  localparam int unsigned SMAC_N_CH  = 4;
  localparam int unsigned SMAC_DEPTH = 8;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mem_req_router_if.sv
// Tagged single-port memory load interface: request side plus tagged response return.
interface mem_req_router_if #(
  parameter int unsigned ADDR_W = mem_req_router_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W = mem_req_router_pkg::MEM_DATA_W,
  parameter int unsigned TAG_W  = mem_req_router_pkg::SMAC_TAG_W
);

  logic              req_mem_ld;
  logic [ADDR_W-1:0] req_mem_addr;
  logic [TAG_W-1:0]  req_mem_tag;
  logic              req_mem_stall;
  logic              rsp_mem_push;
  logic [TAG_W-1:0]  rsp_mem_tag;
  logic [DATA_W-1:0] rsp_mem_q;
  logic              rsp_mem_stall;

  modport master (
    output req_mem_ld, req_mem_addr, req_mem_tag, rsp_mem_stall,
    input  req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
  );

  modport slave (
    input  req_mem_ld, req_mem_addr, req_mem_tag, rsp_mem_stall,
    output req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
  );

endinterface

// File: rtl/smac_rsp_fifo.sv
// Per-channel response FIFO: DEPTH x DATA_W, first word visible on q, occupancy on count.
module smac_rsp_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    pop,
  output logic                    valid,
  output logic [DATA_W-1:0]       q,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  // Pop on empty is ignored; push on full is dropped (the router never lets that happen).
  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign valid = (count_q != '0);
  assign q     = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mem_req_router.sv
// N-channel load router: round-robin, credit-limited issue onto one tagged memory port,
// with tagged responses steered back into per-channel FIFOs.
module mem_req_router
  import mem_req_router_pkg::*;
#(
  parameter int unsigned N_CH   = SMAC_N_CH,
  parameter int unsigned TAG_W  = SMAC_TAG_W,
  parameter int unsigned DEPTH  = SMAC_DEPTH,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_req_ld,
  input  logic [N_CH*ADDR_W-1:0]   ch_req_addr,
  output logic [N_CH-1:0]          ch_req_stall,
  output logic [N_CH-1:0]          ch_rsp_valid,
  output logic [N_CH*DATA_W-1:0]   ch_rsp_q,
  input  logic [N_CH-1:0]          ch_rsp_pop,
  mem_req_router_if.master         mem,
  output logic                     busy,
  output logic                     err_tag
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("mem_req_router: DEPTH must be a power of two");
  end
  if (N_CH > (1 << TAG_W)) begin : g_tag_chk
    $error("mem_req_router: TAG_W too narrow for N_CH");
  end

  logic [N_CH-1:0][CNT_W-1:0] inflight_q;
  logic [N_CH-1:0][CNT_W-1:0] fifo_count;
  logic [N_CH-1:0]            eligible, grant, rsp_hit;
  logic [PTR_W-1:0]           rr_ptr_q, win, cand;
  logic [ADDR_W-1:0]          win_addr;
  logic                       grant_any, slot_free;
  logic                       req_ld_q;
  logic [ADDR_W-1:0]          req_addr_q;
  logic [TAG_W-1:0]           req_tag_q;
  logic                       err_q;

  assign slot_free = !req_ld_q || !mem.req_mem_stall;

  // Credit covers both in-flight loads and data already parked, so a response always fits.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      eligible[i] = ch_req_ld[i] &&
                    (({1'b0, inflight_q[i]} + {1'b0, fifo_count[i]}) < SUM_W'(DEPTH));
    end
  end

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    win       = '0;
    cand      = '0;
    if (slot_free) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        cand = PTR_W'((32'(rr_ptr_q) + k) % N_CH);
        if (!grant_any && eligible[cand]) begin
          grant_any   = 1'b1;
          win         = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) win_addr = ch_req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign ch_req_stall = ~grant;

  // Out-of-range tags match no channel and fall through to the error path.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      rsp_hit[i] = mem.rsp_mem_push && (mem.rsp_mem_tag == TAG_W'(i)) &&
                   (inflight_q[i] != '0) && (fifo_count[i] != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      req_ld_q   <= 1'b0;
      req_addr_q <= '0;
      req_tag_q  <= '0;
      err_q      <= 1'b0;
      inflight_q <= '0;
    end else begin
      if (grant_any) begin
        rr_ptr_q   <= (win == PTR_W'(N_CH - 1)) ? '0 : win + 1'b1;
        req_ld_q   <= 1'b1;
        req_addr_q <= win_addr;
        req_tag_q  <= TAG_W'(win);
      end else if (slot_free) begin
        req_ld_q <= 1'b0;
      end
      err_q <= err_q | (mem.rsp_mem_push & ~(|rsp_hit));
      for (int i = 0; i < N_CH; i++) begin
        inflight_q[i] <= inflight_q[i] + CNT_W'(grant[i]) - CNT_W'(rsp_hit[i]);
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_fifo
    smac_rsp_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rsp_hit[g]),
      .wdata (mem.rsp_mem_q),
      .pop   (ch_rsp_pop[g]),
      .valid (ch_rsp_valid[g]),
      .q     (ch_rsp_q[g*DATA_W +: DATA_W]),
      .count (fifo_count[g])
    );
  end

  always_comb begin
    busy = req_ld_q | (|ch_rsp_valid);
    for (int i = 0; i < N_CH; i++) begin
      if (inflight_q[i] != '0) busy = 1'b1;
    end
  end

  assign mem.req_mem_ld    = req_ld_q;
  assign mem.req_mem_addr  = req_addr_q;
  assign mem.req_mem_tag   = req_tag_q;
  assign mem.rsp_mem_stall = 1'b0;
  assign err_tag           = err_q;

endmodule

// File: tb/tb_mem_req_router.sv
// Directed bench for mem_req_router: vector table plus multi-cycle scoreboarded sequences.
module tb_mem_req_router;

  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      ch_req_ld = '0;
  logic [4*48-1:0] ch_req_addr = '0;
  logic [3:0]      ch_req_stall;
  logic [3:0]      ch_rsp_valid;
  logic [4*64-1:0] ch_rsp_q;
  logic [3:0]      ch_rsp_pop = '0;
  logic            busy, err_tag;

  mem_req_router_if mif ();

  mem_req_router #(
    .N_CH(4), .TAG_W(2), .DEPTH(8), .ADDR_W(48), .DATA_W(64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_req_ld    (ch_req_ld),
    .ch_req_addr  (ch_req_addr),
    .ch_req_stall (ch_req_stall),
    .ch_rsp_valid (ch_rsp_valid),
    .ch_rsp_q     (ch_rsp_q),
    .ch_rsp_pop   (ch_rsp_pop),
    .mem          (mif),
    .busy         (busy),
    .err_tag      (err_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] base(input int i);
    return 48'h40 + 48'(i) * 48'h1000;
  endfunction

  function automatic logic [63:0] dfn(input int tag, input logic [47:0] addr);
    return {8'hA5, 6'd0, 2'(tag), addr};
  endfunction

  typedef struct {
    logic [3:0]  ld;
    logic [3:0]  pop;
    logic        mst;
    logic        push;
    logic [1:0]  ptag;
    logic [63:0] pq;
    logic [3:0]  e_stall;
    logic        e_ld;
    logic [1:0]  e_tag;
    logic [3:0]  e_valid;
    logic        e_busy;
    logic        e_err;
    int          qch;
    logic [63:0] e_q;
  } vec_t;

  typedef struct { int tag; logic [47:0] addr; } exp_t;
  typedef struct { int tag; logic [47:0] addr; int ready; } rsp_t;

  vec_t vq[$];
  exp_t expq[$];
  rsp_t rspq[$];

  int  cyc = 0;
  int  nreq[NC], iss_cnt[NC], gcount[NC], last_ready[NC];
  logic [3:0] ld_en = '0, pop_en = '0;
  bit  auto_rsp = 0;
  int  max_delay = 0;
  int  st_lo = -1, st_hi = -1;
  bit  rr_chk = 0;
  int  rr_next = 0;
  int  rr_ticks = 0;
  bit  prev_hold = 0;
  logic [47:0] prev_addr;
  logic [1:0]  prev_tag;
  logic [3:0]  last_stall, last_valid;
  logic        last_busy;

  task automatic apply();
    ch_req_ld  = ld_en;
    ch_rsp_pop = pop_en;
    for (int i = 0; i < NC; i++) ch_req_addr[i*48 +: 48] = base(i) + 48'(nreq[i]) * 48'd8;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_req_ld = '0;
    ch_rsp_pop = '0;
    mif.req_mem_stall = 1'b0;
    mif.rsp_mem_push = 1'b0;
    mif.rsp_mem_tag = '0;
    mif.rsp_mem_q = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NC; i++) begin
      nreq[i] = 0; iss_cnt[i] = 0; gcount[i] = 0; last_ready[i] = 0;
    end
    expq.delete();
    rspq.delete();
    prev_hold = 0;
    st_lo = -1;
    st_hi = -1;
    rr_next = 0;
    rr_ticks = 0;
  endtask

  // One clock: observe at negedge, then drive the next cycle's inputs just after posedge.
  task automatic tick();
    logic [3:0] g;
    int t, d, r, found;
    @(negedge clk);
    g = ch_req_ld & ~ch_req_stall;
    last_stall = ch_req_stall;
    last_valid = ch_rsp_valid;
    last_busy  = busy;
    chk("one_grant", 64'($countones(g) <= 1), 64'd1);
    if (prev_hold) begin
      chk("hold_ld", 64'(mif.req_mem_ld), 64'd1);
      chk("hold_addr", 64'(mif.req_mem_addr), 64'(prev_addr));
      chk("hold_tag", 64'(mif.req_mem_tag), 64'(prev_tag));
    end
    if (mif.req_mem_ld && mif.req_mem_stall) chk("no_grant_stalled", 64'(g), 64'd0);
    if (rr_chk) begin
      if (rr_ticks > 0) chk("one_ld_per_cycle", 64'(mif.req_mem_ld), 64'd1);
      rr_ticks++;
      for (int i = 0; i < NC; i++) begin
        if (g[i]) begin
          chk("rr_order", 64'(i), 64'(rr_next));
          rr_next = (i + 1) % NC;
        end
      end
    end
    for (int i = 0; i < NC; i++) gcount[i] += int'(g[i]);
    prev_hold = mif.req_mem_ld && mif.req_mem_stall;
    prev_addr = mif.req_mem_addr;
    prev_tag  = mif.req_mem_tag;
    if (mif.req_mem_ld && !mif.req_mem_stall) begin
      t = int'(mif.req_mem_tag);
      chk("issue_addr", 64'(mif.req_mem_addr), 64'(base(t) + 48'(iss_cnt[t]) * 48'd8));
      iss_cnt[t]++;
      expq.push_back('{t, mif.req_mem_addr});
      if (auto_rsp) begin
        d = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
        r = cyc + 1 + d;
        if (r < last_ready[t]) r = last_ready[t];
        last_ready[t] = r;
        rspq.push_back('{t, mif.req_mem_addr, r});
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (ch_rsp_pop[i] && ch_rsp_valid[i]) begin
        found = -1;
        for (int k = 0; k < expq.size(); k++) begin
          if (found < 0 && expq[k].tag == i) found = k;
        end
        if (found < 0) begin
          chk("unexpected_rsp", 64'(i), 64'hFFFF);
        end else begin
          chk("rsp_data", ch_rsp_q[i*64 +: 64], dfn(i, expq[found].addr));
          expq.delete(found);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NC; i++) if (g[i]) nreq[i]++;
    apply();
    mif.req_mem_stall = (cyc >= st_lo) && (cyc < st_hi);
    mif.rsp_mem_push = 1'b0;
    for (int k = 0; k < rspq.size(); k++) begin
      if (rspq[k].ready <= cyc) begin
        mif.rsp_mem_push = 1'b1;
        mif.rsp_mem_tag  = 2'(rspq[k].tag);
        mif.rsp_mem_q    = dfn(rspq[k].tag, rspq[k].addr);
        rspq.delete(k);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int g0;
    mif.req_mem_stall = 1'b0;
    mif.rsp_mem_push  = 1'b0;
    mif.rsp_mem_tag   = '0;
    mif.rsp_mem_q     = '0;
    do_reset();
    apply();

    //           ld    pop  mst push ptag pq         stall ld tag valid bsy err qch q
    vq.push_back('{4'h0, 4'h0, 0, 0, 0, 64'h0,      4'hF, 0, 0, 4'h0, 0, 0, -1, 64'h0});
    vq.push_back('{4'h2, 4'h0, 0, 0, 0, 64'h0,      4'hD, 0, 0, 4'h0, 0, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 1, 1, 64'hD1,     4'hF, 1, 1, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 0, 0, 64'h0,      4'hF, 0, 0, 4'h2, 1, 0,  1, 64'hD1});
    vq.push_back('{4'h0, 4'h2, 0, 0, 0, 64'h0,      4'hF, 0, 0, 4'h2, 1, 0,  1, 64'hD1});
    vq.push_back('{4'h0, 4'h0, 0, 0, 0, 64'h0,      4'hF, 0, 0, 4'h0, 0, 0, -1, 64'h0});
    vq.push_back('{4'hF, 4'h0, 0, 0, 0, 64'h0,      4'hB, 0, 0, 4'h0, 0, 0, -1, 64'h0});
    vq.push_back('{4'hF, 4'h0, 0, 0, 0, 64'h0,      4'h7, 1, 2, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'hF, 4'h0, 0, 0, 0, 64'h0,      4'hE, 1, 3, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'hF, 4'h0, 0, 0, 0, 64'h0,      4'hD, 1, 0, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 0, 0, 64'h0,      4'hF, 1, 1, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 1, 2, 64'hA2,     4'hF, 0, 0, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 1, 0, 64'hA0,     4'hF, 0, 0, 4'h4, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 1, 3, 64'hA3,     4'hF, 0, 0, 4'h5, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 1, 1, 64'hA1,     4'hF, 0, 0, 4'hD, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 0, 0, 64'h0,      4'hF, 0, 0, 4'hF, 1, 0,  3, 64'hA3});
    vq.push_back('{4'h0, 4'hF, 0, 0, 0, 64'h0,      4'hF, 0, 0, 4'hF, 1, 0,  0, 64'hA0});
    vq.push_back('{4'h0, 4'h0, 0, 0, 0, 64'h0,      4'hF, 0, 0, 4'h0, 0, 0, -1, 64'h0});
    vq.push_back('{4'h1, 4'h0, 0, 0, 0, 64'h0,      4'hE, 0, 0, 4'h0, 0, 0, -1, 64'h0});
    vq.push_back('{4'h2, 4'h0, 1, 0, 0, 64'h0,      4'hF, 1, 0, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'h2, 4'h0, 0, 0, 0, 64'h0,      4'hD, 1, 0, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 0, 0, 64'h0,      4'hF, 1, 1, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 1, 0, 64'hB0,     4'hF, 0, 0, 4'h0, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 1, 1, 64'hB1,     4'hF, 0, 0, 4'h1, 1, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h3, 0, 0, 0, 64'h0,      4'hF, 0, 0, 4'h3, 1, 0,  1, 64'hB1});
    vq.push_back('{4'h0, 4'h0, 0, 1, 2, 64'hEE,     4'hF, 0, 0, 4'h0, 0, 0, -1, 64'h0});
    vq.push_back('{4'h0, 4'h0, 0, 0, 0, 64'h0,      4'hF, 0, 0, 4'h0, 0, 1, -1, 64'h0});

    for (int k = 0; k < vq.size(); k++) begin
      v = vq[k];
      ch_req_ld = v.ld;
      ch_rsp_pop = v.pop;
      mif.req_mem_stall = v.mst;
      mif.rsp_mem_push = v.push;
      mif.rsp_mem_tag = v.ptag;
      mif.rsp_mem_q = v.pq;
      @(negedge clk);
      chk($sformatf("v%0d stall", k), 64'(ch_req_stall), 64'(v.e_stall));
      chk($sformatf("v%0d req_ld", k), 64'(mif.req_mem_ld), 64'(v.e_ld));
      if (v.e_ld) begin
        chk($sformatf("v%0d req_tag", k), 64'(mif.req_mem_tag), 64'(v.e_tag));
        chk($sformatf("v%0d req_addr", k), 64'(mif.req_mem_addr), 64'(base(int'(v.e_tag))));
      end
      chk($sformatf("v%0d valid", k), 64'(ch_rsp_valid), 64'(v.e_valid));
      chk($sformatf("v%0d busy", k), 64'(busy), 64'(v.e_busy));
      chk($sformatf("v%0d err", k), 64'(err_tag), 64'(v.e_err));
      if (v.qch >= 0) chk($sformatf("v%0d q", k), ch_rsp_q[v.qch*64 +: 64], v.e_q);
      @(posedge clk);
      #1;
    end

    // Credit limit: ch2 alone, responses arrive but are never popped.
    do_reset();
    ld_en = 4'h4; pop_en = 4'h0; auto_rsp = 1; max_delay = 0;
    apply();
    repeat (12) tick();
    chk("credit_first8", 64'(gcount[2]), 64'd8);
    repeat (4) tick();
    chk("credit_hold", 64'(gcount[2]), 64'd8);
    chk("credit_stall2", 64'(last_stall[2]), 64'd1);
    chk("credit_valid2", 64'(last_valid[2]), 64'd1);
    g0 = gcount[2];
    pop_en = 4'h4;
    apply();
    repeat (3) tick();
    pop_en = 4'h0;
    apply();
    repeat (8) tick();
    chk("credit_more3", 64'(gcount[2] - g0), 64'd3);
    chk("credit_stall2_again", 64'(last_stall[2]), 64'd1);
    ld_en = 4'h0; pop_en = 4'hF;
    apply();
    repeat (20) tick();
    chk("credit_drain_busy", 64'(last_busy), 64'd0);
    chk("credit_drain_exp", 64'(expq.size()), 64'd0);
    chk("credit_err", 64'(err_tag), 64'd0);

    // Round-robin with a 5-cycle back-pressure window mid-burst.
    do_reset();
    ld_en = 4'hF; pop_en = 4'hF; auto_rsp = 1; max_delay = 0;
    apply();
    st_lo = cyc + 10;
    st_hi = cyc + 15;
    rr_chk = 1;
    repeat (30) tick();
    rr_chk = 0;
    st_lo = -1; st_hi = -1;
    ld_en = 4'h0;
    apply();
    repeat (15) tick();
    for (int i = 0; i < NC; i++) chk($sformatf("bp_issued_ch%0d", i), 64'(iss_cnt[i]), 64'(gcount[i]));
    chk("bp_busy", 64'(last_busy), 64'd0);
    chk("bp_exp", 64'(expq.size()), 64'd0);
    chk("bp_err", 64'(err_tag), 64'd0);

    // Out-of-order returns between tag 0 and tag 3.
    do_reset();
    ld_en = 4'h9; pop_en = 4'hF; auto_rsp = 1; max_delay = 10;
    apply();
    repeat (60) tick();
    ld_en = 4'h0;
    apply();
    repeat (40) tick();
    chk("ooo_err", 64'(err_tag), 64'd0);
    chk("ooo_busy", 64'(last_busy), 64'd0);
    chk("ooo_exp", 64'(expq.size()), 64'd0);
    chk("ooo_ch0_issued", 64'(iss_cnt[0]), 64'(gcount[0]));
    chk("ooo_ch3_issued", 64'(iss_cnt[3]), 64'(gcount[3]));

    // Reset with four loads in flight, then late responses.
    do_reset();
    ld_en = 4'hF; pop_en = 4'h0; auto_rsp = 0; max_delay = 0;
    apply();
    repeat (4) tick();
    chk("rst_inflight4", 64'(gcount[0] + gcount[1] + gcount[2] + gcount[3]), 64'd4);
    ld_en = 4'h0;
    do_reset();
    apply();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ld", 64'(mif.req_mem_ld), 64'd0);
    @(posedge clk);
    #1;
    for (int t = 0; t < NC; t++) begin
      mif.rsp_mem_push = 1'b1;
      mif.rsp_mem_tag = 2'(t);
      mif.rsp_mem_q = 64'hDEAD_0000 + 64'(t);
      @(posedge clk);
      #1;
    end
    mif.rsp_mem_push = 1'b0;
    @(negedge clk);
    chk("late_valid", 64'(ch_rsp_valid), 64'd0);
    chk("late_busy", 64'(busy), 64'd0);
    chk("late_err", 64'(err_tag), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
